sy_dma_mem_slv: RTL

- AXI4-subset burst memory responder; the target end of the SoC DMA master port.
- Accepts DMA write and read bursts into an internal word-addressed SRAM model.
- Returns write responses and read data with a programmable read latency.
- One transaction in flight at a time; sits on the DMA master port in the SoC simulation top.

---
 rtl/sy_dma_mem_slv.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sy_dma_mem_slv.sv
// AXI4-subset burst memory responder for the DMA master port: one write or read burst at a time,
// backed by a word-addressed SRAM model with a programmable read latency.
module sy_dma_mem_slv #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              s_awvalid_i,
    output logic              s_awready_o,
    input  logic [ADDR_W-1:0] s_awaddr_i,
    input  logic [7:0]        s_awlen_i,
    input  logic [2:0]        s_awsize_i,
    input  logic [1:0]        s_awburst_i,
    input  logic [ID_W-1:0]   s_awid_i,
    input  logic              s_wvalid_i,
    output logic              s_wready_o,
    input  logic [DATA_W-1:0] s_wdata_i,
    input  logic [7:0]        s_wstrb_i,
    input  logic              s_wlast_i,
    output logic              s_bvalid_o,
    input  logic              s_bready_i,
    output logic [1:0]        s_bresp_o,
    output logic [ID_W-1:0]   s_bid_o,
    input  logic              s_arvalid_i,
    output logic              s_arready_o,
    input  logic [ADDR_W-1:0] s_araddr_i,
    input  logic [7:0]        s_arlen_i,
    input  logic [2:0]        s_arsize_i,
    input  logic [1:0]        s_arburst_i,
    input  logic [ID_W-1:0]   s_arid_i,
    output logic              s_rvalid_o,
    input  logic              s_rready_i,
    output logic [DATA_W-1:0] s_rdata_o,
    output logic [1:0]        s_rresp_o,
    output logic [ID_W-1:0]   s_rid_o,
    output logic              s_rlast_o
);

    localparam int unsigned       IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(DEPTH * 8);
    localparam logic [1:0]        RESP_OK   = 2'b00;
    localparam logic [1:0]        RESP_SLV  = 2'b10;

    typedef enum logic [2:0] {StIdle, StWrData, StWrResp, StRdWait, StRdData} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          len_q;
    logic [7:0]          cnt_q;
    logic [15:0]         lat_q;
    logic [ID_W-1:0]     id_q;
    logic                err_q;
    logic                awready_q, arready_q, wready_q, bvalid_q, rvalid_q, rlast_q;
    logic [1:0]          bresp_q, rresp_q;
    logic [ID_W-1:0]     bid_q, rid_q;
    logic [DATA_W-1:0]   rdata_q;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                aw_hs, ar_hs, w_hs, b_hs, r_hs;
    logic                aw_chk, ar_chk;
    logic                w_inr, w_last, w_beat_err, mem_we;
    logic [ADDR_W-1:0]   ld_addr;
    logic                ld_err, ld_last, ld_inr;
    logic [DATA_W-1:0]   ld_data;
    logic [1:0]          ld_resp;

    // Write wins a same-cycle AW/AR collision, so arready is masked by awvalid.
    assign s_awready_o = awready_q;
    assign s_arready_o = arready_q & ~s_awvalid_i;
    assign s_wready_o  = wready_q;
    assign s_bvalid_o  = bvalid_q;
    assign s_bresp_o   = bresp_q;
    assign s_bid_o     = bid_q;
    assign s_rvalid_o  = rvalid_q;
    assign s_rdata_o   = rdata_q;
    assign s_rresp_o   = rresp_q;
    assign s_rid_o     = rid_q;
    assign s_rlast_o   = rlast_q;

    assign aw_hs = (state_q == StIdle) && awready_q && s_awvalid_i;
    assign ar_hs = (state_q == StIdle) && s_arready_o && s_arvalid_i;
    assign w_hs  = (state_q == StWrData) && wready_q && s_wvalid_i;
    assign b_hs  = bvalid_q && s_bready_i;
    assign r_hs  = rvalid_q && s_rready_i;

    assign aw_chk = (s_awburst_i != 2'b01) || (s_awsize_i != 3'b011) || (s_awaddr_i[2:0] != 3'b000);
    assign ar_chk = (s_arburst_i != 2'b01) || (s_arsize_i != 3'b011) || (s_araddr_i[2:0] != 3'b000);

    assign w_inr      = addr_q < MEM_BYTES;
    assign w_last     = cnt_q == len_q;
    assign w_beat_err = !w_inr || (s_wlast_i != w_last);
    assign mem_we     = w_hs && !err_q && w_inr;

    // Beat about to be presented on R: beat 0 at the request, otherwise the one after addr_q.
    always_comb begin
        ld_addr = addr_q;
        ld_err  = err_q;
        ld_last = len_q == 8'd0;
        case (state_q)
            StIdle: begin
                ld_addr = s_araddr_i;
                ld_err  = ar_chk;
                ld_last = s_arlen_i == 8'd0;
            end
            StRdData: begin
                ld_addr = addr_q + ADDR_W'(8);
                ld_last = (cnt_q + 8'd1) == len_q;
            end
            default: ;
        endcase
        ld_inr  = ld_addr < MEM_BYTES;
        ld_data = ld_inr ? mem[ld_addr[IDX_W+2:3]] : '0;
        ld_resp = (ld_err || !ld_inr) ? RESP_SLV : RESP_OK;
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (s_wstrb_i[b]) mem[addr_q[IDX_W+2:3]][8*b +: 8] <= s_wdata_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            lat_q     <= '0;
            id_q      <= '0;
            err_q     <= 1'b0;
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            bid_q     <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rid_q     <= '0;
            rlast_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    awready_q <= 1'b1;
                    arready_q <= 1'b1;
                    if (aw_hs) begin
                        addr_q    <= s_awaddr_i;
                        len_q     <= s_awlen_i;
                        id_q      <= s_awid_i;
                        err_q     <= aw_chk;
                        cnt_q     <= '0;
                        awready_q <= 1'b0;
                        arready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        state_q   <= StWrData;
                    end else if (ar_hs) begin
                        addr_q    <= s_araddr_i;
                        len_q     <= s_arlen_i;
                        id_q      <= s_arid_i;
                        rid_q     <= s_arid_i;
                        err_q     <= ar_chk;
                        cnt_q     <= '0;
                        awready_q <= 1'b0;
                        arready_q <= 1'b0;
                        if (RD_LAT == 1) begin
                            rvalid_q <= 1'b1;
                            rdata_q  <= ld_data;
                            rresp_q  <= ld_resp;
                            rlast_q  <= ld_last;
                            state_q  <= StRdData;
                        end else begin
                            lat_q   <= 16'(RD_LAT - 1);
                            state_q <= StRdWait;
                        end
                    end
                end
                StWrData: begin
                    if (w_hs) begin
                        if (w_beat_err) err_q <= 1'b1;
                        addr_q <= addr_q + ADDR_W'(8);
                        cnt_q  <= cnt_q + 8'd1;
                        if (w_last) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bid_q    <= id_q;
                            bresp_q  <= (err_q || w_beat_err) ? RESP_SLV : RESP_OK;
                            state_q  <= StWrResp;
                        end
                    end
                end
                StWrResp: begin
                    if (b_hs) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= '0;
                        bid_q     <= '0;
                        awready_q <= 1'b1;
                        arready_q <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                StRdWait: begin
                    // Counter reaching zero on this edge puts beat 0 on the bus RD_LAT cycles in.
                    if (lat_q <= 16'd1) begin
                        lat_q    <= '0;
                        rvalid_q <= 1'b1;
                        rdata_q  <= ld_data;
                        rresp_q  <= ld_resp;
                        rlast_q  <= ld_last;
                        state_q  <= StRdData;
                    end else begin
                        lat_q <= lat_q - 16'd1;
                    end
                end
                StRdData: begin
                    if (r_hs) begin
                        if (cnt_q == len_q) begin
                            rvalid_q  <= 1'b0;
                            rdata_q   <= '0;
                            rresp_q   <= '0;
                            rid_q     <= '0;
                            rlast_q   <= 1'b0;
                            awready_q <= 1'b1;
                            arready_q <= 1'b1;
                            state_q   <= StIdle;
                        end else begin
                            cnt_q   <= cnt_q + 8'd1;
                            addr_q  <= addr_q + ADDR_W'(8);
                            rdata_q <= ld_data;
                            rresp_q <= ld_resp;
                            rlast_q <= ld_last;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
